cpu_dbg_ctl: RTL and testbench

//  Debug command controller directly upstream of the cpu block. It takes a host byte stream (e.g. from a UART rx/tx pair)
//  and drives the CPU's ready and dbgreg_sel inputs, reading dbgreg_out back. Supports halt, run and single-step, register

---
 rtl/cpu_dbg_ctl.sv | 183 ++++++++++++++++++
 tb/tb_cpu_dbg_ctl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_dbg_ctl.sv
// rtl/cpu_dbg_ctl.sv - host byte-stream debug controller for the cpu block
//
// Purpose: decodes single-byte debug opcodes from a host stream and drives the
// CPU's ready and dbgreg_sel inputs. Supports echo, halt, run, single-step,
// debug register reads and halted-status queries. A cpu_brk pulse halts the CPU.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   in_data/in_valid      host command/argument byte, handshaked with in_ready
//   out_data/out_valid    response byte to host, handshaked with out_ready
//   cpu_ready             drives cpu ready (0 = CPU stalled)
//   cpu_brk               one-clock break pulse from the CPU
//   dbgreg_sel/dbgreg_out debug register select and read-back data
//   halted                1 while this block holds the CPU stalled

module cpu_dbg_ctl #(
  parameter int STEP_CLKS    = 4,
  parameter bit RESET_HALTED = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       cpu_ready,
  input  logic       cpu_brk,
  output logic [3:0] dbgreg_sel,
  input  logic [7:0] dbgreg_out,
  output logic       halted
);

  localparam int CW = $clog2(STEP_CLKS + 1);

  localparam logic [7:0] OP_ECHO   = 8'h00;
  localparam logic [7:0] OP_HALT   = 8'h01;
  localparam logic [7:0] OP_RUN    = 8'h02;
  localparam logic [7:0] OP_QUERY  = 8'h03;
  localparam logic [7:0] OP_REG_RD = 8'h04;
  localparam logic [7:0] OP_STEP   = 8'h05;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_REG_WAIT,
    S_STEP,
    S_RESP
  } state_t;

  state_t          r_state;
  logic            r_arg_is_reg;  // ARG byte belongs to REG_RD (1) or ECHO (0)
  logic [7:0]      r_out_data;
  logic            r_out_valid;
  logic            r_cpu_ready;
  logic            r_halted;
  logic [3:0]      r_sel;
  logic [CW-1:0]   r_cnt;

  logic            w_in_ready;
  logic            w_in_fire;

  assign w_in_ready = (r_state == S_IDLE) || (r_state == S_ARG);
  assign w_in_fire  = in_valid && w_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_arg_is_reg <= 1'b0;
      r_out_data   <= 8'h00;
      r_out_valid  <= 1'b0;
      r_cpu_ready  <= ~RESET_HALTED;
      r_halted     <= RESET_HALTED;
      r_sel        <= 4'h0;
      r_cnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_fire) begin
            case (in_data)
              OP_ECHO: begin
                r_arg_is_reg <= 1'b0;
                r_state      <= S_ARG;
              end
              OP_REG_RD: begin
                r_arg_is_reg <= 1'b1;
                r_state      <= S_ARG;
              end
              OP_HALT: begin
                r_cpu_ready <= 1'b0;
                r_halted    <= 1'b1;
                r_out_data  <= OP_HALT;
                r_out_valid <= 1'b1;
                r_state     <= S_RESP;
              end
              OP_RUN: begin
                r_cpu_ready <= 1'b1;
                r_halted    <= 1'b0;
                r_out_data  <= OP_RUN;
                r_out_valid <= 1'b1;
                r_state     <= S_RESP;
              end
              OP_QUERY: begin
                r_out_data  <= {7'b0, r_halted};
                r_out_valid <= 1'b1;
                r_state     <= S_RESP;
              end
              OP_STEP: begin
                if (r_halted) begin
                  // halted stays 1 across the step: the CPU is only lent a
                  // bounded burst of ready cycles.
                  r_cpu_ready <= 1'b1;
                  r_cnt       <= CW'(STEP_CLKS);
                  r_state     <= S_STEP;
                end else begin
                  r_out_data  <= RSP_ERR;
                  r_out_valid <= 1'b1;
                  r_state     <= S_RESP;
                end
              end
              default: begin
                r_out_data  <= RSP_ERR;
                r_out_valid <= 1'b1;
                r_state     <= S_RESP;
              end
            endcase
          end
        end
        S_ARG: begin
          if (w_in_fire) begin
            if (r_arg_is_reg) begin
              r_sel   <= in_data[3:0];
              r_state <= S_REG_WAIT;
            end else begin
              r_out_data  <= in_data;
              r_out_valid <= 1'b1;
              r_state     <= S_RESP;
            end
          end
        end
        S_REG_WAIT: begin
          // dbgreg_sel has had one clock to settle through the CPU mux
          r_out_data  <= dbgreg_out;
          r_out_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_STEP: begin
          if ((r_cnt == CW'(1)) || cpu_brk) begin
            r_cpu_ready <= 1'b0;
            r_out_data  <= OP_STEP;
            r_out_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Break overrides any ready/halted update made above in the same cycle.
      if (cpu_brk) begin
        r_cpu_ready <= 1'b0;
        r_halted    <= 1'b1;
      end
    end
  end

  assign in_ready   = w_in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign cpu_ready  = r_cpu_ready;
  assign halted     = r_halted;
  assign dbgreg_sel = r_sel;

endmodule

// File: tb/tb_cpu_dbg_ctl.sv
// tb/tb_cpu_dbg_ctl.sv - self-checking bench for cpu_dbg_ctl

module tb_cpu_dbg_ctl;

  localparam int STEP_CLKS = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       cpu_ready;
  logic       cpu_brk = 1'b0;
  logic [3:0] dbgreg_sel;
  logic [7:0] dbgreg_out;
  logic       halted;

  logic [7:0] regs [16];
  bit         brk_en = 1'b0;
  bit         brk_force = 1'b0;

  int n_checks = 0;
  int n_err = 0;

  cpu_dbg_ctl #(.STEP_CLKS(STEP_CLKS), .RESET_HALTED(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .cpu_ready  (cpu_ready),
    .cpu_brk    (cpu_brk),
    .dbgreg_sel (dbgreg_sel),
    .dbgreg_out (dbgreg_out),
    .halted     (halted)
  );

  always #10 clk = ~clk;

  // Simple CPU register file model behind the debug mux
  assign dbgreg_out = regs[dbgreg_sel];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 awaiting opcode, 1 awaiting argument, 2 busy, 3 response pending
  int unsigned m_cyc = 0;
  int          m_mode = 0;
  bit          m_arg_reg = 1'b0;
  bit          m_step = 1'b0;
  int unsigned m_end = 0;
  logic [7:0]  m_resp = 8'h00;
  bit          m_halted = 1'b1;
  bit          m_cpu_ready = 1'b0;
  logic [3:0]  m_sel = 4'h0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 0; m_halted = 1'b1; m_cpu_ready = 1'b0; m_sel = 4'h0; m_resp = 8'h00;
      end else begin
        m_cyc++;
        if (m_mode == 3) begin
          if (out_ready) m_mode = 0;
        end else if (m_mode == 0) begin
          if (in_valid) begin
            if (in_data == 8'h00 || in_data == 8'h04) begin
              m_arg_reg = (in_data == 8'h04);
              m_mode = 1;
            end else if (in_data == 8'h01) begin
              m_halted = 1'b1; m_cpu_ready = 1'b0; m_resp = 8'h01; m_mode = 3;
            end else if (in_data == 8'h02) begin
              m_halted = 1'b0; m_cpu_ready = 1'b1; m_resp = 8'h02; m_mode = 3;
            end else if (in_data == 8'h03) begin
              m_resp = {7'b0, m_halted}; m_mode = 3;
            end else if (in_data == 8'h05 && m_halted) begin
              m_cpu_ready = 1'b1; m_step = 1'b1; m_end = m_cyc + STEP_CLKS; m_mode = 2;
            end else begin
              m_resp = 8'hEE; m_mode = 3;
            end
          end
        end else if (m_mode == 1) begin
          if (in_valid) begin
            if (m_arg_reg) begin
              m_sel = in_data[3:0]; m_step = 1'b0; m_end = m_cyc + 1; m_mode = 2;
            end else begin
              m_resp = in_data; m_mode = 3;
            end
          end
        end else begin
          if (m_step) begin
            if (m_cyc == m_end || cpu_brk) begin
              m_cpu_ready = 1'b0; m_resp = 8'h05; m_mode = 3;
            end
          end else if (m_cyc == m_end) begin
            m_resp = regs[m_sel]; m_mode = 3;
          end
        end
        if (cpu_brk) begin
          m_cpu_ready = 1'b0; m_halted = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("in_ready", in_ready, (m_mode <= 1));
        chk("out_valid", out_valid, (m_mode == 3));
        chk("cpu_ready", cpu_ready, m_cpu_ready);
        chk("halted", halted, m_halted);
        chk("dbgreg_sel", dbgreg_sel, m_sel);
        if (m_mode == 3) chk("out_data", out_data, m_resp);
      end
    end
  end

  // Break pulse generator: directed pulses via brk_force, random ones via brk_en
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cpu_brk = brk_force || (brk_en && ($urandom_range(0, 19) == 0));
    end
  end

  // ---------------- host-side tasks ----------------
  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_checks++; n_err++;
    $display("FAIL send_timeout: byte %0h not accepted", b);
    in_valid = 1'b0;
  endtask

  task automatic recv(output logic [7:0] b, input int stall);
    bit seen;
    seen = 1'b0;
    b = 8'h00;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_checks++; n_err++;
      $display("FAIL recv_timeout: no response");
      return;
    end
    repeat (stall) @(negedge clk);
    b = out_data;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] op, output logic [7:0] rsp);
    send(op);
    recv(rsp, 0);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [7:0] rsp;
    int         hi_cnt;
    for (int i = 0; i < 16; i++) regs[i] = 8'($urandom);
    regs[3] = 8'h5A;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_halted", halted, 1);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_sel", dbgreg_sel, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    cmd(8'h03, rsp);
    chk("query_after_reset", rsp, 8'h01);

    send(8'h02);
    @(negedge clk);
    chk("run_latency_valid", out_valid, 1);
    chk("run_cpu_ready", cpu_ready, 1);
    recv(rsp, 0);
    chk("run_rsp", rsp, 8'h02);

    @(posedge clk); brk_force = 1'b1;
    @(posedge clk); brk_force = 1'b0;
    @(negedge clk);
    chk("brk_cpu_ready", cpu_ready, 0);
    chk("brk_halted", halted, 1);
    @(posedge clk); #1;
    cmd(8'h03, rsp);
    chk("query_after_brk", rsp, 8'h01);

    send(8'h05);
    hi_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) break;
      if (cpu_ready) hi_cnt++;
    end
    chk("step_ready_clks", hi_cnt, STEP_CLKS);
    chk("step_ready_after", cpu_ready, 0);
    recv(rsp, 0);
    chk("step_rsp", rsp, 8'h05);

    cmd(8'h02, rsp);
    send(8'h05);
    recv(rsp, 0);
    chk("step_running_rsp", rsp, 8'hEE);
    chk("step_running_ready", cpu_ready, 1);
    cmd(8'h01, rsp);
    chk("halt_rsp", rsp, 8'h01);

    send(8'h04);
    send(8'h03);
    @(negedge clk);
    chk("reg_sel", dbgreg_sel, 4'h3);
    chk("reg_not_yet_valid", out_valid, 0);
    @(negedge clk);
    chk("reg_valid_2clk", out_valid, 1);
    recv(rsp, 0);
    chk("reg_rsp", rsp, 8'h5A);

    send(8'h00);
    send(8'hC3);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("echo_hold_data", out_data, 8'hC3);
      chk("echo_hold_in_ready", in_ready, 0);
      @(negedge clk);
    end
    recv(rsp, 0);
    chk("echo_rsp", rsp, 8'hC3);

    cmd(8'h9F, rsp);
    chk("unknown_rsp", rsp, 8'hEE);

    cmd(8'h02, rsp);
    send(8'h04);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_cpu_ready", cpu_ready, 0);
    chk("midrst_halted", halted, 1);
    chk("midrst_sel", dbgreg_sel, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd(8'h03, rsp);
    chk("midrst_query", rsp, 8'h01);

    brk_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int         r;
      logic [7:0] op;
      r = $urandom_range(0, 7);
      op = (r <= 5) ? 8'(r) : ((r == 6) ? 8'($urandom) : 8'h01);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send(op);
      if (op == 8'h00 || op == 8'h04) begin
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        send(8'($urandom));
      end
      recv(rsp, $urandom_range(0, 3));
    end
    brk_en = 1'b0;

    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
